// File: rtl/tile_match_ctrl.sv
// Tile-matching game sequencer: menu/play/end mode, one/two tile reveal,
// reveal window timing, colour compare, matched mask and move counter.
module tile_match_ctrl #(
  parameter int unsigned NTILES        = 10,
  parameter int unsigned REVEAL_CYCLES = 100000000
) (
  input  logic                  CLOCK_50,
  input  logic                  resetn,
  input  logic                  start,
  input  logic                  quit,
  input  logic [NTILES-1:0]     sw,
  input  logic [4*NTILES-1:0]   tile_color,
  output logic [1:0]            mode,
  output logic [NTILES-1:0]     matched,
  output logic [NTILES-1:0]     shown,
  output logic [3:0]            first_color,
  output logic [3:0]            second_color,
  output logic                  first_valid,
  output logic                  second_valid,
  output logic [7:0]            moves,
  output logic                  game_over
);

  localparam int unsigned IW = (NTILES > 1) ? $clog2(NTILES) : 1;
  localparam int unsigned TW = $clog2(REVEAL_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(REVEAL_CYCLES - 1);

  typedef enum logic [2:0] {
    S_MENU,
    S_IDLE,
    S_ONE,
    S_REVEAL,
    S_END
  } state_t;

  state_t            state_q, state_d;
  logic [NTILES-1:0] sw_q, sw_d;
  logic [NTILES-1:0] matched_q, matched_d;
  logic [7:0]        moves_q, moves_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [IW-1:0]     first_idx_q, first_idx_d;
  logic [IW-1:0]     second_idx_q, second_idx_d;
  logic              first_valid_q, first_valid_d;
  logic              second_valid_q, second_valid_d;
  logic [3:0]        first_color_q, first_color_d;
  logic [3:0]        second_color_q, second_color_d;

  logic [NTILES-1:0] rise;
  logic              cand_ok;
  logic [IW-1:0]     cand_idx;
  logic [3:0]        cand_color;
  logic [NTILES-1:0] first_bit, second_bit, pair_mask;

  // Lowest eligible rising switch wins; the rest of that cycle's edges are dropped.
  always_comb begin
    rise       = sw & ~sw_q;
    cand_ok    = 1'b0;
    cand_idx   = '0;
    cand_color = 4'hF;
    for (int unsigned i = 0; i < NTILES; i++) begin
      if (!cand_ok && rise[i] && !matched_q[i] &&
          (state_q != S_ONE || first_idx_q != IW'(i))) begin
        cand_ok    = 1'b1;
        cand_idx   = IW'(i);
        cand_color = tile_color[4*i +: 4];
      end
    end
  end

  always_comb begin
    first_bit  = NTILES'(1) << first_idx_q;
    second_bit = NTILES'(1) << second_idx_q;
    pair_mask  = (first_valid_q ? first_bit : '0) | (second_valid_q ? second_bit : '0);
  end

  always_comb begin
    state_d        = state_q;
    sw_d           = sw;
    matched_d      = matched_q;
    moves_d        = moves_q;
    timer_d        = timer_q;
    first_idx_d    = first_idx_q;
    second_idx_d   = second_idx_q;
    first_valid_d  = first_valid_q;
    second_valid_d = second_valid_q;
    first_color_d  = first_color_q;
    second_color_d = second_color_q;

    if (quit && state_q != S_MENU) begin
      state_d        = S_MENU;
      timer_d        = '0;
      first_valid_d  = 1'b0;
      second_valid_d = 1'b0;
      first_color_d  = 4'hF;
      second_color_d = 4'hF;
    end else begin
      unique case (state_q)
        S_MENU: begin
          if (start) begin
            state_d        = S_IDLE;
            matched_d      = '0;
            moves_d        = '0;
            timer_d        = '0;
            first_valid_d  = 1'b0;
            second_valid_d = 1'b0;
            first_color_d  = 4'hF;
            second_color_d = 4'hF;
          end
        end
        S_IDLE: begin
          if (cand_ok) begin
            state_d       = S_ONE;
            first_idx_d   = cand_idx;
            first_valid_d = 1'b1;
            first_color_d = cand_color;
          end
        end
        S_ONE: begin
          if (cand_ok) begin
            state_d        = S_REVEAL;
            second_idx_d   = cand_idx;
            second_valid_d = 1'b1;
            second_color_d = cand_color;
            timer_d        = '0;
          end
        end
        S_REVEAL: begin
          timer_d = timer_q + TW'(1);
          if (timer_q == T_LAST) begin
            timer_d        = '0;
            moves_d        = (moves_q == 8'hFF) ? moves_q : moves_q + 8'd1;
            if (first_color_q == second_color_q) begin
              matched_d = matched_q | first_bit | second_bit;
            end
            first_valid_d  = 1'b0;
            second_valid_d = 1'b0;
            first_color_d  = 4'hF;
            second_color_d = 4'hF;
            state_d        = (&matched_d) ? S_END : S_IDLE;
          end
        end
        S_END: begin
        end
        default: state_d = S_MENU;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q        <= S_MENU;
      sw_q           <= '1;
      matched_q      <= '0;
      moves_q        <= '0;
      timer_q        <= '0;
      first_idx_q    <= '0;
      second_idx_q   <= '0;
      first_valid_q  <= 1'b0;
      second_valid_q <= 1'b0;
      first_color_q  <= 4'hF;
      second_color_q <= 4'hF;
    end else begin
      state_q        <= state_d;
      sw_q           <= sw_d;
      matched_q      <= matched_d;
      moves_q        <= moves_d;
      timer_q        <= timer_d;
      first_idx_q    <= first_idx_d;
      second_idx_q   <= second_idx_d;
      first_valid_q  <= first_valid_d;
      second_valid_q <= second_valid_d;
      first_color_q  <= first_color_d;
      second_color_q <= second_color_d;
    end
  end

  always_comb begin
    unique case (state_q)
      S_MENU:  mode = 2'd0;
      S_END:   mode = 2'd2;
      default: mode = 2'd1;
    endcase
    game_over    = (state_q == S_END);
    matched      = matched_q;
    shown        = matched_q | pair_mask;
    moves        = moves_q;
    first_valid  = first_valid_q;
    second_valid = second_valid_q;
    first_color  = first_color_q;
    second_color = second_color_q;
  end

endmodule

// File: doc/tile_match_ctrl.md
# tile_match_ctrl

Sequencing controller for the tile-matching game: owns the menu/play/end mode and the idle, one-tile, two-tile reveal sequence. Turns switch rising edges into tile selections, holds the pair on display for a fixed reveal window, compares colours, and maintains the matched-tile mask, move counter and game-over flag. Sits between board I/O (SW, KEY, sw-derived pulses) and the LEDR/HEX display logic; the colour table is supplied externally.

## Interface

- NTILES, 10, number of tiles and switches
- REVEAL_CYCLES, 100000000, clock cycles the pair stays revealed (2 s at 50 MHz); minimum 2
- CLOCK_50  in  1  system clock
- resetn  in  1  asynchronous, active-low reset
- start  in  1  synchronous pulse, begin a new game (from debounced KEY)
- quit  in  1  synchronous pulse, abandon to menu
- sw  in  NTILES  tile switches, level
- tile_color  in  4*NTILES  colour of tile i at bits [4i+3:4i]; static during play
- mode  out  2  0 = MENU, 1 = PLAY, 2 = END
- matched  out  NTILES  tiles permanently matched
- shown  out  NTILES  matched | currently revealed tiles (drives LEDR)
- first_color, second_color  out  4 each  colours of revealed tiles; 4'hF when not valid
- first_valid, second_valid  out  1 each  revealed-tile flags
- moves  out  8  completed pair attempts, saturates at 255
- game_over  out  1  high in END

## Operation

- States: MENU, IDLE, ONE, REVEAL, END. mode = MENU for MENU, PLAY for IDLE/ONE/REVEAL, END for END.
- sw_q: registered copy of sw, updated every cycle in every state. edge = sw & ~sw_q.
- Candidate = lowest index i with edge[i] = 1, matched[i] = 0, and (state ≠ ONE or i ≠ first index). Other simultaneous edges are discarded, not queued. Falling edges are ignored.
- MENU: start -> clear matched, moves, first/second; go IDLE.
- IDLE: candidate -> latch first index, go ONE.
- ONE: candidate -> latch second index, clear timer, go REVEAL.
- REVEAL: switch edges ignored; timer increments each cycle. At timer = REVEAL_CYCLES-1: moves += 1 (saturating); if colours equal, matched |= both bits; clear first/second; if resulting matched is all ones go END, else IDLE.
- END: holds matched and moves; start ignored.
- quit in any state other than MENU -> MENU next cycle, clears first/second and timer; matched and moves retain values until next start. quit wins over start and over any same-cycle selection or REVEAL completion.
- Selecting the same tile twice is impossible; re-toggling first tile's switch in ONE has no effect.

## Timing

- Reset: state MENU, sw_q all ones (switches already up at reset produce no edge), matched 0, moves 0, timer 0, first/second invalid, colours 4'hF, shown 0, game_over 0.
- Selection latency: edge present before clock edge k -> valid flag and colour registered at edge k.
- Reveal window: second_valid high for exactly REVEAL_CYCLES cycles; at the closing edge, valid flags fall and matched/moves update together.
- All outputs registered or decoded from registers only; no combinational path from sw to outputs.
- game_over asserts the same edge as entry to END.

## Test plan

- Reset with sw = 10'h3FF, release, then start -> mode = 1, no selection, shown = 0.
- Colours tile0 = tile7 = 1; REVEAL_CYCLES = 8; raise sw[0], then sw[7] -> first_color = 1, second_color = 1 for 8 cycles; then matched = 10'h081, moves = 1, mode = 1.
- Mismatch tile1 (colour 2) + tile3 (colour 4) -> shown = 10'h00A during reveal; afterwards matched unchanged, shown = matched, moves increments.
- sw[2] and sw[5] rise same cycle in IDLE -> first = tile2 only; sw[5] toggled again later is selectable.
- Match all five pairs -> mode = 2, game_over = 1, moves = 5; start ignored; quit -> mode = 0.
- quit asserted during REVEAL at timer = REVEAL_CYCLES-1 -> MENU, moves and matched not updated; moves saturation checked by forcing 255 attempts.
